// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO placed in front of one arbiter lane.
// Outputs depend only on registered state, so there is no combinational path from valid_i/ready_i.
module stream_fifo #(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1,
    parameter int COUNT_WIDTH        = $clog2(DEPTH + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   push, pop;

    assign ready_o       = (count_q != FULL_COUNT);
    assign valid_o       = (count_q != '0);
    assign data_o        = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign almost_full_o = ({{(32-COUNT_WIDTH){1'b0}}, count_q} >= 32'(ALMOST_FULL_THRESH));

    // A push coinciding with reset is dropped along with everything else.
    assign push = valid_i && ready_o && !ARESET;
    assign pop  = valid_o && ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; data_o is meaningless while valid_o is low.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and random checks of stream_fifo against a queue-based reference model.
module tb_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    logic          almost_full_o;

    logic [DW-1:0] model_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 ACLK = ~ACLK;

    stream_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ALMOST_FULL_THRESH(AF),
        .COUNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o),
        .almost_full_o(almost_full_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle, then advance the model.
    task automatic cycle(input logic vi, input logic [DW-1:0] di, input logic ri, input logic rst);
        int sz;
        ARESET  = rst;
        valid_i = vi;
        data_i  = di;
        ready_i = ri;
        @(negedge ACLK);
        sz = model_q.size();
        check("valid_o", 32'(valid_o), 32'(sz != 0));
        check("ready_o", 32'(ready_o), 32'(sz != DEPTH));
        check("count_o", 32'(count_o), 32'(sz));
        check("almost_full_o", 32'(almost_full_o), 32'(sz >= AF));
        if (sz != 0) check("data_o", data_o, model_q[0]);
        @(posedge ACLK);
        if (rst) begin
            model_q.delete();
        end else begin
            if (ri && sz != 0) void'(model_q.pop_front());
            if (vi && sz != DEPTH) model_q.push_back(di);
        end
        #1;
    endtask

    initial begin
        ARESET  = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        // Idle after reset, ready_i toggling must not matter.
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'(i % 2), 1'b0);

        // Fill to full with ready_i low; fifth word must be held off.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hA4, 1'b0, 1'b0);
        cycle(1'b1, 32'hA4, 1'b1, 1'b0);
        cycle(1'b1, 32'hA4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming through several pointer wraps.
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Mid-operation reset with a concurrent write that must be dropped.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'hC0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
